// File: rtl/cluster_count_monitor_if.sv
// Sample and slow-control bus of the cluster count monitor.
// master drives the per-BX samples and controls; slave is the monitor itself.
interface cluster_count_monitor_if #(
  parameter int SUM_WIDTH = 24,
  parameter int OVF_WIDTH = 16
);
  logic                 en_i;
  logic                 clear_i;
  logic                 valid_i;
  logic [10:0]          cnt_i;
  logic                 overflow_i;
  logic [SUM_WIDTH-1:0] sum_o;
  logic [OVF_WIDTH-1:0] ovf_cnt_o;
  logic                 sat_o;
  logic                 window_done_o;
  logic [10:0]          peak_o;
  logic                 state_o;

  // valid_i qualifies cnt_i/overflow_i for one cycle; there is no ready, the
  // monitor accepts every sample. window_done_o marks the cycle the outputs change.
  modport master (
    output en_i, clear_i, valid_i, cnt_i, overflow_i,
    input  sum_o, ovf_cnt_o, sat_o, window_done_o, peak_o, state_o
  );
  modport slave (
    input  en_i, clear_i, valid_i, cnt_i, overflow_i,
    output sum_o, ovf_cnt_o, sat_o, window_done_o, peak_o, state_o
  );
endinterface

// File: rtl/cluster_count_monitor.sv
// Accumulates per-BX cluster counts and overflow BXs over WINDOW samples and publishes totals.
// Optional peak tracking is enabled by defining CLUSTER_COUNT_MONITOR_PEAK_EN.
module cluster_count_monitor #(
  parameter int WINDOW    = 3564,
  parameter int SUM_WIDTH = 24,
  parameter int OVF_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  cluster_count_monitor_if.slave  bus
);
  localparam int BXW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [BXW-1:0] BX_LAST = BXW'(WINDOW - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t state, state_next;

  logic [SUM_WIDTH-1:0] acc_sum, sum_q, sum_sat;
  logic [OVF_WIDTH-1:0] acc_ovf, ovf_q, ovf_sat;
  logic [SUM_WIDTH:0]   sum_wide;
  logic [OVF_WIDTH:0]   ovf_wide;
  logic [BXW-1:0]       bx;
  logic                 sat_q, sat_out_q, done_q, sat_next;
  logic                 take, win_end;

  // One extra carry bit; a carry or an all-ones result counts as saturation.
  always_comb begin
    sum_wide = {1'b0, acc_sum} + (SUM_WIDTH + 1)'(bus.cnt_i);
    ovf_wide = {1'b0, acc_ovf} + (OVF_WIDTH + 1)'(bus.overflow_i);
    sum_sat  = sum_wide[SUM_WIDTH] ? '1 : sum_wide[SUM_WIDTH-1:0];
    ovf_sat  = ovf_wide[OVF_WIDTH] ? '1 : ovf_wide[OVF_WIDTH-1:0];
    sat_next = sat_q | (&sum_sat) | (&ovf_sat);
    take     = (state == ACCUM) && bus.valid_i;
    win_end  = take && (bx == BX_LAST);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.en_i)  state_next = ACCUM;
      ACCUM:   if (!bus.en_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_sum <= '0; acc_ovf <= '0; bx <= '0; sat_q <= 1'b0;
      sum_q <= '0; ovf_q <= '0; sat_out_q <= 1'b0; done_q <= 1'b0;
    end else if (bus.clear_i) begin
      acc_sum <= '0; acc_ovf <= '0; bx <= '0; sat_q <= 1'b0;
      sum_q <= '0; ovf_q <= '0; sat_out_q <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (win_end) begin
        sum_q     <= sum_sat;
        ovf_q     <= ovf_sat;
        sat_out_q <= sat_next;
        done_q    <= 1'b1;
      end
      // Idle, leaving ACCUM or closing a window all start the next window from zero.
      if (state != ACCUM || !bus.en_i || win_end) begin
        acc_sum <= '0; acc_ovf <= '0; bx <= '0; sat_q <= 1'b0;
      end else if (take) begin
        acc_sum <= sum_sat;
        acc_ovf <= ovf_sat;
        bx      <= bx + BXW'(1);
        sat_q   <= sat_next;
      end
    end
  end

`ifdef CLUSTER_COUNT_MONITOR_PEAK_EN
  logic [10:0] peak_acc, peak_out_q, peak_next;

  always_comb peak_next = (bus.cnt_i > peak_acc) ? bus.cnt_i : peak_acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      peak_acc <= '0; peak_out_q <= '0;
    end else if (bus.clear_i) begin
      peak_acc <= '0; peak_out_q <= '0;
    end else begin
      if (win_end) peak_out_q <= peak_next;
      if (state != ACCUM || !bus.en_i || win_end) peak_acc <= '0;
      else if (take)                              peak_acc <= peak_next;
    end
  end

  assign bus.peak_o = peak_out_q;
`else
  assign bus.peak_o = '0;
`endif

  assign bus.sum_o         = sum_q;
  assign bus.ovf_cnt_o     = ovf_q;
  assign bus.sat_o         = sat_out_q;
  assign bus.window_done_o = done_q;
  assign bus.state_o       = state;
endmodule

// File: tb/tb_cluster_count_monitor.sv
// Table-driven bench for cluster_count_monitor with WINDOW=4, SUM_WIDTH=11, OVF_WIDTH=2.
// Peak expectations follow CLUSTER_COUNT_MONITOR_PEAK_EN.
module tb_cluster_count_monitor;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cluster_count_monitor_if #(.SUM_WIDTH(11), .OVF_WIDTH(2)) bus ();

  cluster_count_monitor #(.WINDOW(4), .SUM_WIDTH(11), .OVF_WIDTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        en, clr, valid;
    logic [10:0] cnt;
    logic        ovf;
    logic        done;
    logic [10:0] sum;
    logic [1:0]  oc;
    logic        sat;
    logic [10:0] peak;
  } vec_t;

  vec_t vecs[$];
  int applied = 0;
  int miscompares = 0;

  function automatic logic [10:0] pk(input logic [10:0] x);
`ifdef CLUSTER_COUNT_MONITOR_PEAK_EN
    return x;
`else
    return 11'd0;
`endif
  endfunction

  task automatic add(input logic en, clr, valid, input int cnt, input logic ovf,
                     input logic done, input int sum, input int oc, input logic sat,
                     input int peak);
    vec_t v;
    v.en = en; v.clr = clr; v.valid = valid; v.cnt = 11'(cnt); v.ovf = ovf;
    v.done = done; v.sum = 11'(sum); v.oc = 2'(oc); v.sat = sat; v.peak = pk(11'(peak));
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic done, input logic [10:0] sum,
                       input logic [1:0] oc, input logic sat, input logic [10:0] peak);
    applied++;
    if (bus.window_done_o !== done || bus.sum_o !== sum || bus.ovf_cnt_o !== oc ||
        bus.sat_o !== sat || bus.peak_o !== peak) begin
      miscompares++;
      $display("FAIL %s: got done=%0d sum=%0d ovf=%0d sat=%0d peak=%0d, want done=%0d sum=%0d ovf=%0d sat=%0d peak=%0d",
               name, bus.window_done_o, bus.sum_o, bus.ovf_cnt_o, bus.sat_o, bus.peak_o,
               done, sum, oc, sat, peak);
    end
  endtask

  task automatic drive(input logic en, clr, valid, input logic [10:0] cnt, input logic ovf);
    bus.en_i = en; bus.clear_i = clr; bus.valid_i = valid;
    bus.cnt_i = cnt; bus.overflow_i = ovf;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1 check("reset_state", 1'b0, 11'd0, 2'd0, 1'b0, 11'd0);
    reset = 1'b0;

    // basic window: 10,20,30,40 with two overflow BXs
    add(1,0,0,   0,0, 0,   0,0,0,   0);
    add(1,0,1,  10,0, 0,   0,0,0,   0);
    add(1,0,1,  20,1, 0,   0,0,0,   0);
    add(1,0,1,  30,0, 0,   0,0,0,   0);
    add(1,0,1,  40,1, 1, 100,2,0,  40);
    // eight back-to-back samples of 5
    for (int i = 0; i < 2; i++) begin
      add(1,0,1, 5,0, 0, (i == 0) ? 100 : 20, (i == 0) ? 2 : 0, 0, (i == 0) ? 40 : 5);
      add(1,0,1, 5,0, 0, (i == 0) ? 100 : 20, (i == 0) ? 2 : 0, 0, (i == 0) ? 40 : 5);
      add(1,0,1, 5,0, 0, (i == 0) ? 100 : 20, (i == 0) ? 2 : 0, 0, (i == 0) ? 40 : 5);
      add(1,0,1, 5,0, 1, 20,0,0, 5);
    end
    // sum and overflow saturation, then a clean window
    add(1,0,1,1536,1, 0,  20,0,0,   5);
    add(1,0,1,1536,1, 0,  20,0,0,   5);
    add(1,0,1,1536,1, 0,  20,0,0,   5);
    add(1,0,1,1536,1, 1,2047,3,1,1536);
    add(1,0,1,   1,0, 0,2047,3,1,1536);
    add(1,0,1,   1,0, 0,2047,3,1,1536);
    add(1,0,1,   1,0, 0,2047,3,1,1536);
    add(1,0,1,   1,0, 1,   4,0,0,   1);
    // valid gaps, non-valid data must be ignored
    add(1,0,1,   3,0, 0,   4,0,0,   1);
    add(1,0,0,1000,1, 0,   4,0,0,   1);
    add(1,0,0,1000,1, 0,   4,0,0,   1);
    add(1,0,1,   3,0, 0,   4,0,0,   1);
    add(1,0,1,   3,0, 0,   4,0,0,   1);
    add(1,0,0, 999,0, 0,   4,0,0,   1);
    add(1,0,1,   3,0, 1,  12,0,0,   3);
    // partial window discarded on en_i drop; IDLE ignores valid
    add(1,0,1,   7,0, 0,  12,0,0,   3);
    add(1,0,1,   7,0, 0,  12,0,0,   3);
    add(0,0,0,   0,0, 0,  12,0,0,   3);
    add(0,0,1,  99,1, 0,  12,0,0,   3);
    add(1,0,1,  99,1, 0,  12,0,0,   3);
    add(1,0,1,   7,0, 0,  12,0,0,   3);
    add(1,0,1,   7,0, 0,  12,0,0,   3);
    add(1,0,1,   7,0, 0,  12,0,0,   3);
    add(1,0,1,   7,0, 1,  28,0,0,   7);
    // clear on the window-end sample wins
    add(1,0,1,   2,0, 0,  28,0,0,   7);
    add(1,0,1,   2,0, 0,  28,0,0,   7);
    add(1,0,1,   2,0, 0,  28,0,0,   7);
    add(1,1,1,   2,0, 0,   0,0,0,   0);
    add(1,0,1,   2,0, 0,   0,0,0,   0);
    add(1,0,1,   2,0, 0,   0,0,0,   0);
    add(1,0,1,   2,0, 0,   0,0,0,   0);
    add(1,0,1,   2,0, 1,   8,0,0,   2);
    // en_i drop on a window end still publishes
    add(1,0,1,   3,0, 0,   8,0,0,   2);
    add(1,0,1,   3,0, 0,   8,0,0,   2);
    add(1,0,1,   3,0, 0,   8,0,0,   2);
    add(0,0,1,   3,0, 1,  12,0,0,   3);
    add(0,0,1,   3,0, 0,  12,0,0,   3);
    add(1,0,0,   0,0, 0,  12,0,0,   3);
    add(1,0,1,   5,0, 0,  12,0,0,   3);
    add(1,0,1,   5,0, 0,  12,0,0,   3);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].valid, vecs[i].cnt, vecs[i].ovf);
      @(posedge clock);
      #1 check($sformatf("vec%0d", i), vecs[i].done, vecs[i].sum, vecs[i].oc,
               vecs[i].sat, vecs[i].peak);
    end

    // async reset mid-window clears outputs without waiting for a clock edge
    #2 reset = 1'b1;
    #1 check("async_reset", 1'b0, 11'd0, 2'd0, 1'b0, 11'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 11'd9, 1'b1);
    @(posedge clock);
    #1 check("post_reset", 1'b0, 11'd0, 2'd0, 1'b0, 11'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/cluster_count_monitor.md
Name: cluster_count_monitor

Overview:
Consumes the registered per-BX cluster count and overflow flag from the cluster counter, one sample per BX.
- Accumulates the counts over a fixed window of BXs, defaulting to one LHC orbit.
- Counts the overflow BXs in the same window.
- Publishes the window totals to slow-control registers with a one-cycle done strobe.
- Sits directly downstream of the cluster counter, in the same clock domain.

Parameters:
WINDOW, 3564, number of valid samples per accumulation window (legal range 2 to 2^16)
SUM_WIDTH, 24, width of the cluster-sum accumulator and of sum_o
OVF_WIDTH, 16, width of the overflow-BX counter and of ovf_cnt_o

Ports:
clock  in  1  fabric clock, shared with the cluster counter
reset  in  1  asynchronous, active-high reset
en_i  in  1  monitor enable, level
clear_i  in  1  synchronous clear of accumulators and published outputs
valid_i  in  1  sample strobe; cnt_i and overflow_i are valid this cycle
cnt_i  in  11  cluster count for this BX, 0..1536
overflow_i  in  1  overflow flag for this BX
sum_o  out  SUM_WIDTH  published cluster sum of the last complete window
ovf_cnt_o  out  OVF_WIDTH  published overflow-BX count of the last complete window
sat_o  out  1  sum or overflow count saturated in the last published window
window_done_o  out  1  one-cycle pulse when sum_o, ovf_cnt_o and sat_o update
peak_o  out  11  peak cnt_i in the last published window (see optional feature)

Behaviour:
- Reset (async assert, release synchronous to clock):
  - State is IDLE.
  - All outputs are 0.
  - Accumulators, BX counter and saturation flag are 0.
- State IDLE:
  - Accumulators are held at 0 and valid_i is ignored.
  - en_i=1 -> ACCUM on the next cycle, with the BX counter at 0.
- State ACCUM, each cycle with valid_i=1:
  - acc_sum += cnt_i, saturating at 2^SUM_WIDTH-1; reaching saturation sets the internal sat flag.
  - acc_ovf += overflow_i, saturating at 2^OVF_WIDTH-1; reaching saturation sets the internal sat flag.
  - The BX counter increments.
  - Without valid_i: all internal state holds.
- Window end: the cycle where valid_i=1 and the BX counter equals WINDOW-1.
  - On the next clock edge, sum_o = acc_sum + cnt_i (saturated) and ovf_cnt_o = acc_ovf + overflow_i (saturated).
  - On the same edge, sat_o takes the sat flag, including saturation caused by this final sample.
  - window_done_o=1 for exactly that one cycle.
  - On the same edge, the accumulators, sat flag and BX counter load 0.
  - The state remains ACCUM, so a back-to-back valid_i on the following cycle is counted in the new window and no sample is lost.
- Latency: published outputs and the done pulse appear 1 clock after the last sample of the window is presented.
- en_i=0 in ACCUM:
  - -> IDLE on the next cycle and the partial window is discarded.
  - Published outputs retain their last values and no done pulse is generated.
  - If this cycle is also a window end, the window still publishes, then the block goes to IDLE.
- clear_i=1 (any state):
  - Accumulators, sat flag, BX counter and all published outputs load 0 on the next edge.
  - window_done_o is 0 in the following cycle.
  - clear_i overrides a simultaneous valid_i or window end, and that sample is dropped.
  - State is IDLE if en_i=0, else ACCUM restarting at BX 0.
- Width rules: cnt_i is zero-extended to SUM_WIDTH before the add. The saturating add uses one extra carry bit and clamps.
- No outputs are combinational from inputs; all are registered.

Optional Feature:
- Macro CLUSTER_COUNT_MONITOR_PEAK_EN.
- Defined:
  - An internal 11-bit peak register tracks max(cnt_i) over valid samples in the current window, including the final sample.
  - It is published to peak_o with the same timing as sum_o.
  - It clears with the accumulators, on clear_i, and on entry to IDLE.
- Undefined: peak_o is tied to 0 and no peak logic is synthesised.

Test Plan:
- WINDOW=4, en_i=1, four valid samples cnt_i=10,20,30,40, overflow_i=0,1,0,1 -> 1 cycle after the 4th sample: window_done_o pulses once, sum_o=100, ovf_cnt_o=2, sat_o=0, peak_o=40 (PEAK_EN defined) or 0 (undefined).
- WINDOW=4, continuous valid for 8 cycles with cnt_i=5 -> two done pulses 4 cycles apart, sum_o=20 both times (no sample lost at the window boundary).
- WINDOW=4, SUM_WIDTH=11, cnt_i=1536 on four samples -> sum_o=2047, sat_o=1. Next window with cnt_i=1 on four samples -> sum_o=4, sat_o=0.
- WINDOW=4, valid gaps (valid_i=1,0,0,1,1,0,1) with cnt_i=3 -> done pulse 1 cycle after the 4th valid sample, sum_o=12.
- WINDOW=4, deassert en_i after 2 samples, then reassert for 4 samples of cnt_i=7 -> no done pulse for the partial window, then sum_o=28.
- clear_i asserted on the 4th sample of a window -> no done pulse, all outputs 0, the next full window of cnt_i=2 gives sum_o=8. Async reset mid-window -> all outputs 0 immediately.
